// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing one register-file write port between the ALU/load pipe (A)
// and the mul/div unit (B). A has fixed priority; B gets one forced grant after a bounded wait.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DW           = 64,
  parameter int AW           = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_wn,
  input  logic [DW-1:0] a_wd,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_wn,
  input  logic [DW-1:0] b_wd,
  output logic          b_ready,
  output logic          RegWrite,
  output logic [AW-1:0] WN,
  output logic [DW-1:0] WD,
  output logic          force_b
);

  typedef enum logic {PRI_A, FORCE_B} state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } wb_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  wb_t        wb_q, wb_d;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    case (state_q)
      PRI_A: begin
        a_ready = a_valid;
        b_ready = b_valid && !a_valid;
        if (b_valid && a_valid) begin
          if (starve_q == LIMIT_M1) begin
            state_d  = FORCE_B;
            starve_d = 4'd0;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      FORCE_B: begin
        // Leave after one cycle whether B was granted or (illegally) withdrew.
        b_ready  = b_valid;
        state_d  = PRI_A;
        starve_d = 4'd0;
      end
      default: state_d = PRI_A;
    endcase
    if (!rst_n) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  always_comb begin
    wb_d    = wb_q;
    wb_d.we = 1'b0;
    if (a_ready) begin
      wb_d.we = (a_wn != '0);
      wb_d.wn = a_wn;
      wb_d.wd = a_wd;
    end else if (b_ready) begin
      wb_d.we = (b_wn != '0);
      wb_d.wn = b_wn;
      wb_d.wd = b_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PRI_A;
      starve_q <= 4'd0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wb_q     <= wb_d;
    end
  end

  assign RegWrite = wb_q.we;
  assign WN       = wb_q.wn;
  assign WD       = wb_q.wd;
  assign force_b  = (state_q == FORCE_B);

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/WN/WD, 32 x 64-bit registers, written on negedge clk) between two writeback requesters.
- Requester A is the single-cycle ALU/load pipe. Requester B is the multi-cycle multiply/divide unit.
- A has fixed priority. A starvation counter forces one grant to B after a bounded wait.
- Outputs are registered on posedge clk, so the register file's negedge write sees stable values half a cycle later.

Parameters:
- STARVE_LIMIT, 4: max consecutive cycles B may lose arbitration while valid; legal range 1..15.
- DW, 64: write-data width.
- AW, 5: register-number width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- a_valid  input  1  A has a writeback pending.
- a_wn  input  AW  A destination register.
- a_wd  input  DW  A write data.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  B has a writeback pending.
- b_wn  input  AW  B destination register.
- b_wd  input  DW  B write data.
- b_ready  output  1  B accepted this cycle (combinational).
- RegWrite  output  1  write enable to register file (registered).
- WN  output  AW  write register number (registered).
- WD  output  DW  write data (registered).
- force_b  output  1  high while in FORCE_B state (debug/perf).

Behaviour:
- Handshake: a transfer occurs when valid && ready on a posedge.
- Once asserted, valid and its wn/wd are held stable until accepted; requesters must not withdraw.
- FSM states: PRI_A (reset state) and FORCE_B.
- Starvation counter starve_cnt is wide enough for STARVE_LIMIT.
- Ready logic:
  - PRI_A: a_ready = a_valid; b_ready = b_valid && !a_valid.
  - FORCE_B: a_ready = 0; b_ready = b_valid.
  - While rst_n low, both readys are 0.
- Counter and transitions in PRI_A:
  - b_valid && a_valid (B loses): if starve_cnt == STARVE_LIMIT-1, go to FORCE_B and clear starve_cnt; else increment starve_cnt.
  - b_valid low, or B accepted: clear starve_cnt.
- Transitions in FORCE_B:
  - B accepted: return to PRI_A; starve_cnt stays 0.
  - b_valid low (protocol violation): return to PRI_A without a grant.
- Result: B is granted no later than the (STARVE_LIMIT+1)-th cycle of continuous b_valid.
- Output stage, on each posedge:
  - If a transfer occurred: WN <= winner wn; WD <= winner wd; RegWrite <= (winner wn != 0).
  - Otherwise: RegWrite <= 0; WN and WD hold their previous values.
- Latency: exactly 1 cycle from accept edge to RegWrite high. At most one write per cycle; no buffering.
- x0 writes: wn == 0 is accepted (ready asserted normally) but produces RegWrite = 0. WN/WD still update.
- Same destination from both sides, both valid: A is written first. B is written on a later cycle, so B's value is the final one. No merging.
- Reset (rst_n low at a posedge), including mid-operation: state = PRI_A, starve_cnt = 0, RegWrite = 0, WN = 0, WD = 0, force_b = 0. Any in-flight unaccepted request is ignored; requesters re-present after reset.
- STARVE_LIMIT = 1: B may lose only one cycle before being forced.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles with a_valid = b_valid = 1 -> a_ready = b_ready = 0, RegWrite = 0, WN = 0, WD = 0. Release -> a_ready = 1 on the first cycle.
2. Single A write: a_valid = 1, a_wn = 3, a_wd = 64'h1234 for 1 cycle -> a_ready = 1. Next cycle RegWrite = 1, WN = 3, WD = 64'h1234. Following cycle RegWrite = 0.
3. Starvation, STARVE_LIMIT = 4: a_valid held 1 (a_wn 1..n), b_valid = 1, b_wn = 7, b_wd = 99 from cycle 0 -> b_ready low cycles 0-3, force_b high cycle 4, a_ready = 0 and b_ready = 1 in cycle 4. Cycle 5: WN = 7, WD = 99, and A resumes.
4. Idle-A grant: a_valid = 0, b_valid = 1, b_wn = 5 -> b_ready = 1 same cycle. Next cycle RegWrite = 1, WN = 5. starve_cnt stays 0.
5. x0 write: a_valid = 1, a_wn = 0, a_wd = 64'hFF -> a_ready = 1. Next cycle RegWrite = 0, WN = 0, WD = 64'hFF.
6. Mid-operation reset: after 2 B-losing cycles (starve_cnt = 2), assert rst_n = 0 for 1 cycle -> starve_cnt = 0, state = PRI_A. After release, B needs a full 4 more losing cycles before force_b.
